serial_adder: RTL and testbench

Bit-serial ripple adder. It adds two WIDTH-bit operands plus a carry-in one bit per clock, using a single one-bit full-adder stage (F = A^B^Ci, Co = majority(A,B,Ci)) and a carry flip-flop. It is the sequential datapath stage built around the one-bit full adder: it feeds that stage operand bits LSB-first and collects its F/Co outputs into a result register. It trades latency for area against a parallel ripple adder, and serves as the ALU's low-cost add path.

---
 rtl/serial_adder_if.sv | 17 +
 rtl/serial_adder.sv | 93 +++++++++
 tb/tb_serial_adder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage plus a carry flop, LSB first,
// WIDTH cycles per add, result collected into a registered sum.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start, last result held
  // RUN   | one operand bit added per cycle
  // DONE  | result valid, done pulse high
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic fa_f;
  logic fa_co;

  assign fa_f  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= fa_f;
          carry_q      <= fa_co;
          a_q          <= {1'b0, a_q[WIDTH-1:1]};
          b_q          <= {1'b0, b_q[WIDTH-1:1]};
          // carry_q here is the carry into the MSB on the final bit
          if (cnt_q == LAST) begin
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: timestamp/arithmetic reference model checked every
// cycle, directed corner cases with literal expectations, random sweep.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ovf, cout, sum} from plain arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, full[W], s};
  endfunction

  // Model: edge count n, accepting edge acc, old and new results
  bit             op_valid = 1'b0;
  int             acc = 0;
  int             n = 1;
  int             accepts = 0;
  int             d;
  bit             eb, ed;
  logic [W+1:0]   res_old = '0;
  logic [W+1:0]   res_new = '0;
  logic [W+1:0]   vis;

  initial begin
    forever begin
      @(negedge clk);
      d   = n - acc;
      eb  = op_valid && (d >= 0) && (d <= W - 1);
      ed  = op_valid && (d == W);
      vis = (op_valid && d >= W) ? res_new : res_old;
      chk("busy", bus.busy, eb);
      chk("done", bus.done, ed);
      chk("cout", bus.cout, vis[W]);
      chk("ovf", bus.ovf, vis[W+1]);
      if (!eb) chk("sum", bus.sum, vis[W-1:0]);
      if (rst) begin
        op_valid = 1'b0;
        res_old  = '0;
        res_new  = '0;
      end else if (bus.start && (!op_valid || (n + 1 - acc) >= W + 2)) begin
        res_old  = vis;
        res_new  = ref_add(bus.a, bus.b, bus.cin);
        acc      = n + 1;
        op_valid = 1'b1;
        accepts++;
      end
      n++;
    end
  end

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    int nbusy;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = -1;
    nbusy = 0;
    for (int k = 0; k < 3 * W && lat < 0; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) lat = k;
    end
    chk("latency", lat, W);
    chk("busy_cycles", nbusy, W);
    chk("lit_sum", bus.sum, es);
    chk("lit_cout", bus.cout, ec);
    chk("lit_ovf", bus.ovf, eo);
  endtask

  int lat2;
  int ndone;
  int target;
  int cyc;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);

    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add(8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1);

    // start pulsed during RUN must be ignored
    @(posedge clk); #1;
    bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat2 = -1;
    for (int k = 0; k < 3 * W && lat2 < 0; k++) begin
      @(negedge clk);
      if (bus.done) lat2 = k;
    end
    chk("ign_seen_done", lat2 >= 0, 1);
    chk("ign_sum", bus.sum, 8'h33);
    chk("ign_cout", bus.cout, 0);

    // reset in RUN cycle 4 aborts with no done pulse
    @(posedge clk); #1;
    bus.a = 8'h55; bus.b = 8'h55; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_sum", bus.sum, 0);
    chk("abort_cout", bus.cout, 0);
    chk("abort_ovf", bus.ovf, 0);
    ndone = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // random sweep: start often high (re-trigger), rare resets
    target = accepts + 1000;
    cyc = 0;
    while (accepts < target && cyc < 60000) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 2) != 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      cyc++;
    end
    rst = 1'b0;
    bus.start = 1'b0;
    chk("sweep_count", accepts >= target, 1);
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
